// File: rtl/segled_pkg.sv
// Shared 7-segment pattern constants (bit0=a .. bit6=g), used by both the
// hex->7-segment encoder and the segment-scan decoder.
package segled_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Indexed by nibble value, so a table scan yields the value directly.
  localparam logic [6:0] SEG_LUT [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

endpackage

// File: rtl/seg7_to_nibble.sv
// Combinational reverse lookup of a 7-segment pattern: exact match against
// the 16 encoder patterns, plus a separate blank indication.
module seg7_to_nibble
  import segled_pkg::*;
(
  input  logic [6:0] seg,
  output logic       ok,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    ok     = 1'b0;
    nibble = 4'h0;
    blank  = (seg == SEG_BLANK);
    for (int v = 0; v < 16; v++) begin
      if (seg == SEG_LUT[v]) begin
        ok     = 1'b1;
        nibble = 4'(v);
      end
    end
  end

endmodule

// File: rtl/segscan_decoder.sv
// Samples a multiplexed 7-segment bus, waits for the {seg,dig} word to be
// stable, and decodes the pattern of the enabled digit into a hex nibble.
module segscan_decoder
  import segled_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter bit SEG_ACT_LOW   = 1'b0,
  parameter bit DIG_ACT_LOW   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_in,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   nibbles,
  output logic [DIGITS-1:0]     valid,
  output logic [DIGITS-1:0]     bad,
  output logic                  upd,
  output logic [2:0]            upd_idx
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [6:0]        SEG_INV = SEG_ACT_LOW ? '1 : '0;
  localparam logic [DIGITS-1:0] DIG_INV = DIG_ACT_LOW ? '1 : '0;

  // Raw sync flops reset to the inactive level so the normalised word is 0.
  logic [6:0]        seg_s1, seg_s2;
  logic [DIGITS-1:0] dig_s1, dig_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= SEG_INV;
      seg_s2 <= SEG_INV;
      dig_s1 <= DIG_INV;
      dig_s2 <= DIG_INV;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      dig_s1 <= dig_in;
      dig_s2 <= dig_s1;
    end
  end

  logic [6:0]        seg_n;
  logic [DIGITS-1:0] dig_n;
  assign seg_n = seg_s2 ^ SEG_INV;
  assign dig_n = dig_s2 ^ DIG_INV;

  logic [6:0]        seg_p;
  logic [DIGITS-1:0] dig_p;
  logic [CW-1:0]     cnt;
  logic              same;

  assign same = ({seg_n, dig_n} == {seg_p, dig_p});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p <= '0;
      dig_p <= '0;
      cnt   <= '0;
    end else begin
      seg_p <= seg_n;
      dig_p <= dig_n;
      if (!same)
        cnt <= '0;
      else if (cnt != CW'(STABLE_CYCLES))
        cnt <= cnt + 1'b1;
    end
  end

  logic dig_onehot;
  logic cap;
  assign dig_onehot = (dig_p != '0) && ((dig_p & (dig_p - 1'b1)) == '0);
  // Saturation at STABLE_CYCLES keeps cnt from revisiting STABLE_CYCLES-1.
  assign cap = same && (cnt == CW'(STABLE_CYCLES - 1)) && dig_onehot;

  logic [2:0] cap_idx;
  always_comb begin
    cap_idx = 3'd0;
    for (int i = 0; i < DIGITS; i++)
      if (dig_p[i]) cap_idx = cap_idx | 3'(i);
  end

  logic       dec_ok;
  logic       dec_blank;
  logic [3:0] dec_nib;

  seg7_to_nibble u_dec (
    .seg    (seg_p),
    .ok     (dec_ok),
    .blank  (dec_blank),
    .nibble (dec_nib)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nibbles <= '0;
      valid   <= '0;
      bad     <= '0;
      upd     <= 1'b0;
      upd_idx <= 3'd0;
    end else begin
      upd <= cap;
      if (cap) upd_idx <= cap_idx;
      for (int i = 0; i < DIGITS; i++) begin
        if (cap && dig_p[i]) begin
          if (dec_ok) nibbles[4*i +: 4] <= dec_nib;
          valid[i] <= dec_ok;
          bad[i]   <= !dec_ok && !dec_blank;
        end
      end
      // Clear takes priority over a same-cycle capture for the flags only.
      if (clr) begin
        valid <= '0;
        bad   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_segscan_decoder.sv
// Directed bench for segscan_decoder with DIGITS=4, STABLE_CYCLES=4,
// active-high inputs; expected values are hand-derived constants.
module tb_segscan_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_in;
  logic        clr;
  logic [15:0] nibbles;
  logic [3:0]  valid;
  logic [3:0]  bad;
  logic        upd;
  logic [2:0]  upd_idx;

  int n_checks;
  int n_fail;
  int upd_cnt;
  logic [2:0] last_idx;
  int base;

  segscan_decoder #(
    .DIGITS(4), .STABLE_CYCLES(4), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_in(dig_in), .clr(clr),
    .nibbles(nibbles), .valid(valid), .bad(bad), .upd(upd), .upd_idx(upd_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // upd pulse monitor: samples the registered value present before each edge
  initial begin
    upd_cnt  = 0;
    last_idx = 3'd0;
  end
  always @(posedge clk) begin
    if (upd) begin
      upd_cnt  = upd_cnt + 1;
      last_idx = upd_idx;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] d, input logic [6:0] s);
    dig_in = d;
    seg_in = s;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clr      = 1'b0;
    drive(4'b0000, 7'h00);
    step(2);

    check("rst_nibbles", 32'(nibbles), 32'h0);
    check("rst_valid",   32'(valid),   32'h0);
    check("rst_bad",     32'(bad),     32'h0);
    check("rst_upd",     32'(upd),     32'h0);
    check("rst_upd_idx", 32'(upd_idx), 32'h0);
    rst_n = 1'b1;
    step(1);

    // 1: digit 0 shows '3'; upd lands after edge N+6 and lasts one cycle
    base = upd_cnt;
    drive(4'b0001, 7'b1001111);
    step(6);
    check("t1_upd_early", 32'(upd), 32'h0);
    step(1);
    check("t1_upd_on",    32'(upd), 32'h1);
    check("t1_upd_idx",   32'(upd_idx), 32'h0);
    step(1);
    check("t1_upd_off",   32'(upd), 32'h0);
    step(2);
    check("t1_pulses",    32'(upd_cnt - base), 32'd1);
    check("t1_last_idx",  32'(last_idx), 32'h0);
    check("t1_nibble0",   32'(nibbles[3:0]), 32'h3);
    check("t1_valid",     32'(valid), 32'b0001);
    check("t1_bad",       32'(bad), 32'h0);

    // 2: scan 1,A,C,F across digits 0..3
    base = upd_cnt;
    drive(4'b0001, 7'h06); step(8);
    drive(4'b0010, 7'h77); step(8);
    drive(4'b0100, 7'h39); step(8);
    drive(4'b1000, 7'h71); step(8);
    check("t2_nibbles",  32'(nibbles), 32'hFCA1);
    check("t2_valid",    32'(valid), 32'b1111);
    check("t2_pulses",   32'(upd_cnt - base), 32'd4);
    check("t2_last_idx", 32'(last_idx), 32'd3);

    // 3: segments toggle every 3 clocks, never stable long enough
    base = upd_cnt;
    for (int k = 0; k < 10; k++) begin
      drive(4'b0010, (k % 2 == 0) ? 7'h5B : 7'h6D);
      step(3);
    end
    check("t3_pulses",  32'(upd_cnt - base), 32'd0);
    check("t3_nibbles", 32'(nibbles), 32'hFCA1);
    check("t3_valid",   32'(valid), 32'b1111);
    check("t3_bad",     32'(bad), 32'h0);

    // 4: undecodable pattern on digit 2
    base = upd_cnt;
    drive(4'b0100, 7'b0000001); step(8);
    check("t4_pulses",  32'(upd_cnt - base), 32'd1);
    check("t4_bad",     32'(bad), 32'b0100);
    check("t4_valid",   32'(valid), 32'b1011);
    check("t4_nibbles", 32'(nibbles), 32'hFCA1);

    // 5: two-hot then no digit: no capture
    base = upd_cnt;
    drive(4'b1100, 7'h7F); step(8);
    drive(4'b0000, 7'h7F); step(8);
    check("t5_pulses",  32'(upd_cnt - base), 32'd0);
    check("t5_nibbles", 32'(nibbles), 32'hFCA1);
    check("t5_valid",   32'(valid), 32'b1011);
    check("t5_bad",     32'(bad), 32'b0100);
    // clr on the same edge as a capture of '7' on digit 0
    drive(4'b0001, 7'h07);
    step(6);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t5_clr_upd",     32'(upd), 32'h1);
    check("t5_clr_upd_idx", 32'(upd_idx), 32'h0);
    check("t5_clr_valid",   32'(valid), 32'h0);
    check("t5_clr_bad",     32'(bad), 32'h0);
    check("t5_clr_nibbles", 32'(nibbles), 32'hFCA7);
    step(2);

    // 6: reset at counter=2, then a full window again
    drive(4'b1000, 7'h79);
    step(5);
    rst_n = 1'b0;
    #1;
    check("t6_rst_nibbles", 32'(nibbles), 32'h0);
    check("t6_rst_valid",   32'(valid), 32'h0);
    check("t6_rst_bad",     32'(bad), 32'h0);
    check("t6_rst_upd",     32'(upd), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(6);
    check("t6_upd_early", 32'(upd), 32'h0);
    step(1);
    check("t6_upd_on",    32'(upd), 32'h1);
    check("t6_upd_idx",   32'(upd_idx), 32'd3);
    check("t6_nibbles",   32'(nibbles), 32'hE000);
    check("t6_valid",     32'(valid), 32'b1000);
    step(2);

    // 7: blank pattern clears valid without flagging bad and keeps the nibble
    drive(4'b0010, 7'h6F); step(8);
    check("t7_nibbles", 32'(nibbles), 32'hE090);
    check("t7_valid",   32'(valid), 32'b1010);
    base = upd_cnt;
    drive(4'b0010, 7'h00); step(8);
    check("t7_blank_pulses",  32'(upd_cnt - base), 32'd1);
    check("t7_blank_valid",   32'(valid), 32'b1000);
    check("t7_blank_bad",     32'(bad), 32'h0);
    check("t7_blank_nibbles", 32'(nibbles), 32'hE090);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
